// File: rtl/spi_flash_rd.sv
// spi_flash_rd: SPI-flash READ (0x03) burst sequencer.
// It is the only master of an SPI byte-engine register port. For each burst it
// selects the device and shifts out the opcode, the 24-bit address and one dummy
// byte for every data byte. Each received byte goes out on a valid/ready port.
// It then deselects the device and pulses o_done.
module spi_flash_rd #(
   parameter logic [7:0] CMD       = 8'h03,
   parameter logic       SS_ACTIVE = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic [23:0] i_addr,
   input  logic [15:0] i_len,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_rd_data,
   output logic        o_rd_valid,
   input  logic        i_rd_ready,
   output logic        o_spi_addr,
   output logic        o_spi_cs,
   output logic        o_spi_we,
   output logic [7:0]  o_spi_dat,
   input  logic [7:0]  i_spi_dat,
   input  logic        i_spi_irq
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_SEL,
      S_SEND,
      S_WAIT,
      S_OUT,
      S_DESEL,
      S_DONE
   } state_t;

   state_t      state;
   logic [23:0] addr_q;
   logic [15:0] remaining;
   logic [2:0]  idx;       // 0 = opcode, 1..3 = address bytes, 4 = data phase (saturates)
   logic [7:0]  tx_byte;

   // Pick the byte to shift out for the current position in the burst.
   always_comb begin
      case (idx)
         3'd0:    tx_byte = CMD;
         3'd1:    tx_byte = addr_q[23:16];
         3'd2:    tx_byte = addr_q[15:8];
         3'd3:    tx_byte = addr_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   // Burst sequencer. Every output is registered and changes together with the state.
   always_ff @(posedge i_clk) begin
      // NOTE: the reset is synchronous, so it is only a priority branch inside the
      // clocked block. All state uses non-blocking assignments, so every register
      // sees the values from before the edge.
      if (i_reset) begin
         state      <= S_INIT;
         o_busy     <= 1'b1;
         o_done     <= 1'b0;
         o_rd_valid <= 1'b0;
         o_rd_data  <= 8'h00;
         o_spi_cs   <= 1'b0;
         o_spi_we   <= 1'b0;
         o_spi_addr <= 1'b1;
         o_spi_dat  <= 8'h00;
         addr_q     <= 24'h000000;
         remaining  <= 16'h0000;
         idx        <= 3'd0;
      end else begin
         // Strobes and the done pulse last one cycle. Register select rests on rx/tx.
         o_spi_cs   <= 1'b0;
         o_spi_we   <= 1'b0;
         o_spi_addr <= 1'b1;
         o_done     <= 1'b0;

         case (state)
            S_INIT: begin
               // Force the device deselected after any reset.
               o_spi_cs   <= 1'b1;
               o_spi_we   <= 1'b1;
               o_spi_addr <= 1'b0;
               o_spi_dat  <= {7'b0, ~SS_ACTIVE};
               o_busy     <= 1'b0;
               state      <= S_IDLE;
            end

            S_IDLE: begin
               if (i_req) begin
                  o_busy <= 1'b1;
                  if (i_len != 16'h0000) begin
                     addr_q    <= i_addr;
                     remaining <= i_len;
                     idx       <= 3'd0;
                     state     <= S_SEL;
                  end else begin
                     // An empty burst completes at once and makes no SPI traffic.
                     o_done <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_SEL: begin
               o_spi_cs   <= 1'b1;
               o_spi_we   <= 1'b1;
               o_spi_addr <= 1'b0;
               o_spi_dat  <= {7'b0, SS_ACTIVE};
               state      <= S_SEND;
            end

            S_SEND: begin
               o_spi_cs  <= 1'b1;
               o_spi_we  <= 1'b1;
               o_spi_dat <= tx_byte;
               state     <= S_WAIT;
            end

            S_WAIT: begin
               if (i_spi_irq) begin
                  if (idx < 3'd4) begin
                     // Header byte finished. Its rx data carries nothing and is dropped.
                     idx   <= idx + 3'd1;
                     state <= S_SEND;
                  end else begin
                     o_rd_data  <= i_spi_dat;
                     o_rd_valid <= 1'b1;
                     state      <= S_OUT;
                  end
               end
            end

            S_OUT: begin
               // The SPI engine stays idle until the consumer takes the byte.
               if (i_rd_ready) begin
                  o_rd_valid <= 1'b0;
                  remaining  <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     state <= S_DESEL;
                  end else begin
                     state <= S_SEND;
                  end
               end
            end

            S_DESEL: begin
               o_spi_cs   <= 1'b1;
               o_spi_we   <= 1'b1;
               o_spi_addr <= 1'b0;
               o_spi_dat  <= {7'b0, ~SS_ACTIVE};
               o_done     <= 1'b1;
               state      <= S_DONE;
            end

            S_DONE: begin
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule
